// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared encodings, FSM state type and counter sizing
// for the iterative multiply/divide unit.
package mcycle_pkg;

  localparam logic OP_MUL      = 1'b0;
  localparam logic OP_DIV      = 1'b1;
  localparam logic OP_SIGNED   = 1'b0;
  localparam logic OP_UNSIGNED = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_DONE
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/mcycle_if.sv
// mcycle_if: Execute-stage request / result bundle of the
// multi-cycle unit. master = Execute stage, slave = mcycle_unit.
interface mcycle_if #(
  parameter int WIDTH = 32
);

  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic [3:0]       WA3;
  logic [3:0]       MCycleWA3;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start,
    output MCycleOp,
    output Operand1,
    output Operand2,
    output WA3,
    input  MCycleWA3,
    input  Result1,
    input  Result2,
    input  Busy,
    input  Done
  );

  modport slave (
    input  Start,
    input  MCycleOp,
    input  Operand1,
    input  Operand2,
    input  WA3,
    output MCycleWA3,
    output Result1,
    output Result2,
    output Busy,
    output Done
  );

endinterface

// File: rtl/mcycle_signfix.sv
// mcycle_signfix: conditional two's-complement negate, used for
// operand magnitudes and for result sign correction.
module mcycle_signfix #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? ((~din) + W'(1)) : din;

endmodule

// File: rtl/mcycle_unit.sv
// mcycle_unit: iterative shift-add multiply / restoring divide.
// MCYCLE_EARLY_TERM_EN: multiply stops once the multiplier drains.
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic   CLK,
  input logic   RESET,
  mcycle_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam int W2 = 2 * WIDTH;

  state_t state, state_n;

  logic             load;
  logic             step;
  logic             last;

  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [CW-1:0]    cnt;

  logic [W2-1:0]    a_q;
  logic [W2-1:0]    p_q;
  logic [WIDTH-1:0] b_q;

  logic [W2-1:0]    a_n;
  logic [W2-1:0]    p_n;
  logic [WIDTH-1:0] b_n;

  logic [WIDTH-1:0] res1;
  logic [WIDTH-1:0] res2;
  logic [3:0]       wa3_q;
  logic             busy_q;
  logic             done_q;

  logic             sgn;
  logic             s1;
  logic             s2;
  logic             op2_zero;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] rem_sub;
  logic             ge;

  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign sgn      = (bus.MCycleOp[0] == OP_SIGNED);
  assign s1       = sgn & bus.Operand1[WIDTH-1];
  assign s2       = sgn & bus.Operand2[WIDTH-1];
  assign op2_zero = (bus.Operand2 == '0);

  mcycle_signfix #(.W(WIDTH)) u_mag1 (
    .neg  (s1),
    .din  (bus.Operand1),
    .dout (mag1)
  );

  mcycle_signfix #(.W(WIDTH)) u_mag2 (
    .neg  (s2),
    .din  (bus.Operand2),
    .dout (mag2)
  );

  // p_q holds the product for multiply, {rem, quo} for divide
  assign shifted = p_q[W2-1:WIDTH-1];
  assign ge      = (shifted >= {1'b0, b_q});
  assign rem_sub = shifted[WIDTH-1:0] - b_q;

  always_comb begin
    a_n = a_q;
    b_n = b_q;
    p_n = p_q;
    if (is_div) begin
      p_n = {(ge ? rem_sub : shifted[WIDTH-1:0]),
             p_q[WIDTH-2:0], ge};
    end else begin
      p_n = b_q[0] ? (p_q + a_q) : p_q;
      a_n = a_q << 1;
      b_n = b_q >> 1;
    end
  end

  always_comb begin
    last = (cnt == '0);
`ifdef MCYCLE_EARLY_TERM_EN
    if (!is_div && (b_n == '0)) begin
      last = 1'b1;
    end
`endif
  end

  mcycle_signfix #(.W(W2)) u_prod_fix (
    .neg  (neg_q),
    .din  (p_n),
    .dout (prod_fix)
  );

  mcycle_signfix #(.W(WIDTH)) u_quo_fix (
    .neg  (neg_q),
    .din  (p_n[WIDTH-1:0]),
    .dout (quo_fix)
  );

  mcycle_signfix #(.W(WIDTH)) u_rem_fix (
    .neg  (neg_r),
    .din  (p_n[W2-1:WIDTH]),
    .dout (rem_fix)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.Start) begin
          load    = 1'b1;
          state_n = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        step = 1'b1;
        if (last) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= S_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      res1   <= '0;
      res2   <= '0;
      wa3_q  <= '0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n == S_COMPUTE);
      done_q <= (state_n == S_DONE);
      if (load) begin
        is_div <= (bus.MCycleOp[1] == OP_DIV);
        // a zero divisor keeps the all-ones quotient unsigned-looking
        neg_q  <= (s1 ^ s2) &
                  ~((bus.MCycleOp[1] == OP_DIV) & op2_zero);
        neg_r  <= s1;
        cnt    <= CW'(WIDTH - 1);
        a_q    <= {{WIDTH{1'b0}}, mag1};
        b_q    <= mag2;
        p_q    <= (bus.MCycleOp[1] == OP_DIV) ?
                  {{WIDTH{1'b0}}, mag1} : '0;
        wa3_q  <= bus.WA3;
      end else if (step) begin
        cnt <= cnt - CW'(1);
        a_q <= a_n;
        b_q <= b_n;
        p_q <= p_n;
        if (last) begin
          res1 <= is_div ? quo_fix : prod_fix[WIDTH-1:0];
          res2 <= is_div ? rem_fix : prod_fix[W2-1:WIDTH];
        end
      end
    end
  end

  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Result1   = res1;
  assign bus.Result2   = res2;
  assign bus.MCycleWA3 = wa3_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// tb_mcycle_unit: directed vector table, hand-written corner cases
// and random operations checked against an arithmetic model.
module tb_mcycle_unit;

  localparam int W = 32;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  mcycle_if #(.WIDTH(W)) bus ();

  mcycle_unit #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  wa;
    logic [31:0] r1;
    logic [31:0] r2;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // returns {Result2, Result1}
  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    int     ia, ib;
    logic [63:0] p;
    if (!op[1]) begin
      if (op[0]) begin
        p = {32'b0, a} * {32'b0, b};
      end else begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = 64'(sa * sb);
      end
      return p;
    end
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (op[0]) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {32'h0, 32'h8000_0000};
    ia = $signed(a);
    ib = $signed(b);
    return {32'(ia % ib), 32'(ia / ib)};
  endfunction

  function automatic int lat(input logic [1:0] op,
                             input logic [31:0] b);
    int n;
    logic [31:0] mag;
    n   = W;
    mag = b;
`ifdef MCYCLE_EARLY_TERM_EN
    if (!op[1]) begin
      if (!op[0] && b[31]) mag = -b;
      n = 1;
      for (int i = 0; i < W; i++)
        if (mag[i]) n = i + 1;
    end
`endif
    return n;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] wa,
                        input logic [63:0] exp, input int n,
                        input int poke, input string tag);
    int cyc;
    bit seen;
    @(negedge CLK);
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    bus.WA3      = wa;
    @(posedge CLK);
    #1;
    bus.Start    = 1'b0;
    bus.Operand1 = $urandom;
    bus.Operand2 = $urandom;
    bus.WA3      = 4'($urandom);
    bus.MCycleOp = 2'($urandom);
    cyc  = 1;
    seen = 0;
    while (!seen && cyc <= 100) begin
      bus.Start = (cyc == poke);
      check({tag, " wa3"}, 64'(bus.MCycleWA3), 64'(wa));
      check({tag, " busy&done"}, 64'(bus.Busy & bus.Done), 64'd0);
      if (bus.Done) begin
        seen = 1;
        check({tag, " done_cycle"}, 64'(cyc), 64'(n + 1));
        check({tag, " result1"}, 64'(bus.Result1), 64'(exp[31:0]));
        check({tag, " result2"}, 64'(bus.Result2), 64'(exp[63:32]));
      end else begin
        check({tag, " busy"}, 64'(bus.Busy), 64'd1);
      end
      @(posedge CLK);
      #1;
      cyc++;
    end
    bus.Start = 1'b0;
    check({tag, " timeout"}, 64'(seen), 64'd1);
    check({tag, " done_once"}, 64'(bus.Done), 64'd0);
    check({tag, " hold_r1"}, 64'(bus.Result1), 64'(exp[31:0]));
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, 64'(bus.Busy), 64'd0);
    check({tag, " done"}, 64'(bus.Done), 64'd0);
    check({tag, " r1"}, 64'(bus.Result1), 64'd0);
    check({tag, " r2"}, 64'(bus.Result2), 64'd0);
    check({tag, " wa3"}, 64'(bus.MCycleWA3), 64'd0);
  endtask

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [3:0]  wa;

    vt[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd1,
              32'h0000_0001, 32'hFFFF_FFFE};
    vt[1] = '{2'b10, 32'hFFFF_FFF9, 32'd2, 4'd5,
              32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vt[2] = '{2'b11, 32'd100, 32'd0, 4'd2,
              32'hFFFF_FFFF, 32'd100};
    vt[3] = '{2'b00, 32'd3, 32'hFFFF_FFFC, 4'd3,
              32'hFFFF_FFF4, 32'hFFFF_FFFF};
    vt[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'd4,
              32'h8000_0000, 32'h0};
    vt[5] = '{2'b10, 32'hFFFF_FFFB, 32'd0, 4'd6,
              32'hFFFF_FFFF, 32'hFFFF_FFFB};
    vt[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 4'd7,
              32'h0, 32'h4000_0000};
    vt[7] = '{2'b11, 32'd7, 32'hFFFF_FFFF, 4'd8,
              32'h0, 32'd7};
    vt[8] = '{2'b10, 32'd7, 32'hFFFF_FFFE, 4'd9,
              32'hFFFF_FFFD, 32'd1};
    vt[9] = '{2'b01, 32'd0, 32'd12345, 4'd15,
              32'h0, 32'h0};

    bus.Start    = 1'b0;
    bus.MCycleOp = 2'b00;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    bus.WA3      = '0;

    #1 RESET = 1'b1;
    #2;
    check_zero("reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].wa,
             {vt[i].r2, vt[i].r1}, lat(vt[i].op, vt[i].b), 0,
             $sformatf("vec%0d", i));
    end

    // a second Start while busy must be ignored
    run_op(2'b11, 32'd1000, 32'd7, 4'd11, {32'd6, 32'd142},
           W, 10, "poke");
    for (int i = 0; i < 40; i++) begin
      check("poke no_extra_done", 64'(bus.Done), 64'd0);
      check("poke idle_busy", 64'(bus.Busy), 64'd0);
      @(posedge CLK);
      #1;
    end

    // asynchronous reset in the middle of a divide
    @(negedge CLK);
    bus.Start    = 1'b1;
    bus.MCycleOp = 2'b10;
    bus.Operand1 = 32'hFFFF_FF9C;
    bus.Operand2 = 32'd7;
    bus.WA3      = 4'd12;
    @(posedge CLK);
    #1;
    bus.Start = 1'b0;
    repeat (14) @(posedge CLK);
    #1;
    check("mid busy", 64'(bus.Busy), 64'd1);
    #2 RESET = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge CLK);
    RESET = 1'b0;
    run_op(2'b11, 32'hDEAD_BEEF, 32'h1234, 4'd13,
           model(2'b11, 32'hDEAD_BEEF, 32'h1234), W, 0, "after_rst");

    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom);
      a  = pick();
      b  = pick();
      wa = 4'($urandom);
      run_op(op, a, b, wa, model(op, a, b), lat(op, b), 0,
             $sformatf("rnd%0d op%0d %h %h", i, op, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
